multicore_interrupt_controller: RTL and testbench

Next-generation interrupt controller. Collects NUM_SOURCES edge-triggered interrupt lines and routes each one to the lowest-indexed eligible idle core. It provides fixed priority, per-core enable masks, a programmable vector PC per source, a stall-aware trigger hold and an explicit end-of-service acknowledge. It sits between the peripherals/MMIO bus and the NUM_CORES processor front-ends.

---
 rtl/intc_defs.sv | 29 ++
 rtl/intc_core_fsm.sv | 95 +++++++++
 rtl/multicore_interrupt_controller.sv | 153 +++++++++++++++
 tb/tb_multicore_interrupt_controller.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/intc_defs.sv
// Shared encodings and helpers for the multicore interrupt controller:
// per-core FSM states, config register map and the lowest-index picker.
package intc_defs;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ASSERT  = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  localparam logic [7:0] VEC_BASE = 8'h00;
  localparam logic [7:0] EN_BASE  = 8'h40;
  localparam logic [7:0] PEND     = 8'h80;
  localparam logic [7:0] SWSET    = 8'h81;
  localparam logic [7:0] PENDCLR  = 8'h82;

  // Index of the lowest set bit; returns 0 for an all-zero vector.
  function automatic logic [4:0] lowest_set(input logic [31:0] v);
    logic [4:0] r;
    r = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) begin
        r = i[4:0];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/intc_core_fsm.sv
// Per-core claim/announce/service sequencer. Claims the lowest candidate
// source while idle, holds the trigger through stalls, waits for the ack.
module intc_core_fsm
  import intc_defs::*;
#(
  parameter int NUM_SOURCES  = 8,
  parameter int ADDRESS_BITS = 20,
  parameter int ID_BITS      = 5
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_SOURCES-1:0]            cand,
  input  logic                              stall,
  input  logic                              ack,
  input  logic [NUM_SOURCES*ADDRESS_BITS-1:0] vectors,
  output logic [NUM_SOURCES-1:0]            claim,
  output logic [ADDRESS_BITS-1:0]           pc,
  output logic [ID_BITS-1:0]                id,
  output logic                              trigger
);

  logic [1:0]              state_q, state_d;
  logic [ADDRESS_BITS-1:0] pc_q, pc_d;
  logic [ID_BITS-1:0]      id_q, id_d;
  logic                    trig_q, trig_d;
  logic [4:0]              pick;

  // Next-state, claim selection and latched PC/ID.
  always_comb begin
    pick    = lowest_set(32'(cand));
    claim   = {NUM_SOURCES{1'b0}};
    state_d = state_q;
    pc_d    = pc_q;
    id_d    = id_q;
    trig_d  = trig_q;
    case (state_q)
      ST_IDLE: begin
        if (|cand) begin
          for (int s = 0; s < NUM_SOURCES; s++) begin
            claim[s] = (pick == s[4:0]);
            if (claim[s]) begin
              pc_d = vectors[s*ADDRESS_BITS +: ADDRESS_BITS];
            end else begin
              pc_d = pc_d;
            end
          end
          id_d    = ID_BITS'(pick);
          state_d = ST_ASSERT;
          trig_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ASSERT: begin
        if (!stall) begin
          state_d = ST_SERVICE;
          trig_d  = 1'b0;
        end else begin
          trig_d  = 1'b1;
        end
      end
      ST_SERVICE: begin
        if (ack) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SERVICE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        trig_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= {ADDRESS_BITS{1'b0}};
      id_q    <= {ID_BITS{1'b0}};
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      id_q    <= id_d;
      trig_q  <= trig_d;
    end
  end

  assign pc      = pc_q;
  assign id      = id_q;
  assign trigger = trig_q;

endmodule

// File: rtl/multicore_interrupt_controller.sv
// Edge-triggered interrupt collector with config space, routing each pending
// source to the lowest-indexed idle core that has it enabled.
module multicore_interrupt_controller
  import intc_defs::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20,
  parameter int NUM_CORES    = 2,
  parameter int NUM_SOURCES  = 8,
  parameter int ID_BITS      = 5
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_CORES-1:0]              stall,
  input  logic [NUM_SOURCES-1:0]            irq_in,
  input  logic [NUM_CORES-1:0]              interrupt_ack,
  input  logic                              cfg_we,
  input  logic                              cfg_re,
  input  logic [7:0]                        cfg_addr,
  input  logic [DATA_WIDTH-1:0]             cfg_wdata,
  output logic [DATA_WIDTH-1:0]             cfg_rdata,
  output logic [NUM_CORES*ADDRESS_BITS-1:0] interrupt_PC_out,
  output logic [NUM_CORES*ID_BITS-1:0]      interrupt_ID_out,
  output logic [NUM_CORES-1:0]              interrupt_trigger_out
);

  logic [NUM_SOURCES-1:0]            irq_prev_q, pend_q, pend_d, claimed_all;
  logic [NUM_SOURCES-1:0]            en_q [NUM_CORES];
  logic [NUM_SOURCES-1:0]            en_d [NUM_CORES];
  logic [ADDRESS_BITS-1:0]           vec_q [NUM_SOURCES];
  logic [ADDRESS_BITS-1:0]           vec_d [NUM_SOURCES];
  logic [NUM_SOURCES*ADDRESS_BITS-1:0] vec_flat;
  logic [DATA_WIDTH-1:0]             rdata_q, rdata_d;
  logic                              unused_wdata;

  assign unused_wdata = ^cfg_wdata;

  // A source taken by a lower core is masked from every higher core.
  for (genvar c = 0; c < NUM_CORES; c++) begin : gen_core
    logic [NUM_SOURCES-1:0] taken_in, taken_out, cand, claim;
    if (c == 0) begin : g_first
      assign taken_in = {NUM_SOURCES{1'b0}};
    end else begin : g_chain
      assign taken_in = gen_core[c-1].taken_out;
    end
    assign cand      = pend_q & en_q[c] & ~taken_in;
    assign taken_out = taken_in | claim;

    intc_core_fsm #(
      .NUM_SOURCES (NUM_SOURCES),
      .ADDRESS_BITS(ADDRESS_BITS),
      .ID_BITS     (ID_BITS)
    ) u_fsm (
      .clock  (clock),
      .reset  (reset),
      .cand   (cand),
      .stall  (stall[c]),
      .ack    (interrupt_ack[c]),
      .vectors(vec_flat),
      .claim  (claim),
      .pc     (interrupt_PC_out[c*ADDRESS_BITS +: ADDRESS_BITS]),
      .id     (interrupt_ID_out[c*ID_BITS +: ID_BITS]),
      .trigger(interrupt_trigger_out[c])
    );
  end

  assign claimed_all = gen_core[NUM_CORES-1].taken_out;

  // Pending update: claims and W1C clear first, new edges and SW set win.
  always_comb begin
    pend_d = pend_q & ~claimed_all;
    if (cfg_we && (cfg_addr == PENDCLR)) begin
      pend_d = pend_d & ~cfg_wdata[NUM_SOURCES-1:0];
    end else begin
      pend_d = pend_d;
    end
    pend_d = pend_d | (irq_in & ~irq_prev_q);
    if (cfg_we && (cfg_addr == SWSET)) begin
      pend_d = pend_d | cfg_wdata[NUM_SOURCES-1:0];
    end else begin
      pend_d = pend_d;
    end
  end

  // Vector and enable register writes.
  always_comb begin
    vec_flat = {(NUM_SOURCES*ADDRESS_BITS){1'b0}};
    for (int s = 0; s < NUM_SOURCES; s++) begin
      vec_flat[s*ADDRESS_BITS +: ADDRESS_BITS] = vec_q[s];
      if (cfg_we && (cfg_addr == (VEC_BASE + s[7:0]))) begin
        vec_d[s] = cfg_wdata[ADDRESS_BITS-1:0];
      end else begin
        vec_d[s] = vec_q[s];
      end
    end
    for (int c = 0; c < NUM_CORES; c++) begin
      if (cfg_we && (cfg_addr == (EN_BASE + c[7:0]))) begin
        en_d[c] = cfg_wdata[NUM_SOURCES-1:0];
      end else begin
        en_d[c] = en_q[c];
      end
    end
  end

  // Read mux; the registered value holds between read strobes.
  always_comb begin
    rdata_d = rdata_q;
    if (cfg_re) begin
      rdata_d = {DATA_WIDTH{1'b0}};
      if (cfg_addr == PEND) begin
        rdata_d[NUM_SOURCES-1:0] = pend_q;
      end else begin
        rdata_d = rdata_d;
      end
      for (int s = 0; s < NUM_SOURCES; s++) begin
        if (cfg_addr == (VEC_BASE + s[7:0])) begin
          rdata_d[ADDRESS_BITS-1:0] = vec_q[s];
        end else begin
          rdata_d = rdata_d;
        end
      end
      for (int c = 0; c < NUM_CORES; c++) begin
        if (cfg_addr == (EN_BASE + c[7:0])) begin
          rdata_d[NUM_SOURCES-1:0] = en_q[c];
        end else begin
          rdata_d = rdata_d;
        end
      end
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Config, pending and edge-history registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      irq_prev_q <= {NUM_SOURCES{1'b0}};
      pend_q     <= {NUM_SOURCES{1'b0}};
      rdata_q    <= {DATA_WIDTH{1'b0}};
      for (int s = 0; s < NUM_SOURCES; s++) vec_q[s] <= {ADDRESS_BITS{1'b0}};
      for (int c = 0; c < NUM_CORES; c++) en_q[c] <= {NUM_SOURCES{1'b0}};
    end else begin
      irq_prev_q <= irq_in;
      pend_q     <= pend_d;
      rdata_q    <= rdata_d;
      for (int s = 0; s < NUM_SOURCES; s++) vec_q[s] <= vec_d[s];
      for (int c = 0; c < NUM_CORES; c++) en_q[c] <= en_d[c];
    end
  end

  assign cfg_rdata = rdata_q;

endmodule

// File: tb/tb_multicore_interrupt_controller.sv
// Bench for multicore_interrupt_controller: behavioural model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_multicore_interrupt_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  stall, interrupt_ack;
  logic [7:0]  irq_in;
  logic        cfg_we, cfg_re;
  logic [7:0]  cfg_addr;
  logic [31:0] cfg_wdata, cfg_rdata;
  logic [39:0] pc_out;
  logic [9:0]  id_out;
  logic [1:0]  trig_out;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: phase 0 = free, 1 = announcing to fetch, 2 = running its ISR.
  bit [7:0]  m_pend, m_prev;
  bit [7:0]  m_en [2];
  bit [19:0] m_vec [8];
  bit [31:0] m_rdata;
  int        m_phase [2];
  bit [19:0] m_pc [2];
  bit [4:0]  m_id [2];

  multicore_interrupt_controller dut (
    .clock(clock), .reset(reset), .stall(stall), .irq_in(irq_in),
    .interrupt_ack(interrupt_ack), .cfg_we(cfg_we), .cfg_re(cfg_re),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .interrupt_PC_out(pc_out), .interrupt_ID_out(id_out),
    .interrupt_trigger_out(trig_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit [31:0] model_read(input bit [7:0] a);
    if (a == 8'h80) return {24'd0, m_pend};
    if (a < 8'd8) return {12'd0, m_vec[a[2:0]]};
    if (a == 8'h40 || a == 8'h41) return {24'd0, m_en[a[0]]};
    return 32'd0;
  endfunction

  task automatic model_step();
    bit [7:0] taken, avail, npend;
    bit       found;
    if (!reset) begin
      m_pend = 8'd0; m_prev = 8'd0; m_rdata = 32'd0;
      for (int i = 0; i < 8; i++) m_vec[i] = 20'd0;
      for (int c = 0; c < 2; c++) begin
        m_en[c] = 8'd0; m_phase[c] = 0; m_pc[c] = 20'd0; m_id[c] = 5'd0;
      end
    end else begin
      if (cfg_re) m_rdata = model_read(cfg_addr);
      taken = 8'd0;
      for (int c = 0; c < 2; c++) begin
        if (m_phase[c] == 0) begin
          avail = m_pend & m_en[c] & ~taken;
          found = 1'b0;
          for (int s = 0; s < 8; s++) begin
            if (avail[s] && !found) begin
              found = 1'b1; taken[s] = 1'b1;
              m_pc[c] = m_vec[s]; m_id[c] = 5'(s); m_phase[c] = 1;
            end
          end
        end else if (m_phase[c] == 1) begin
          if (!stall[c]) m_phase[c] = 2;
        end else begin
          if (interrupt_ack[c]) m_phase[c] = 0;
        end
      end
      npend = m_pend & ~taken;
      if (cfg_we) begin
        if (cfg_addr == 8'h82) npend = npend & ~cfg_wdata[7:0];
        if (cfg_addr == 8'h81) npend = npend | cfg_wdata[7:0];
        if (cfg_addr < 8'd8) m_vec[cfg_addr[2:0]] = cfg_wdata[19:0];
        if (cfg_addr == 8'h40 || cfg_addr == 8'h41) m_en[cfg_addr[0]] = cfg_wdata[7:0];
      end
      npend = npend | (irq_in & ~m_prev);
      m_pend = npend;
      m_prev = irq_in;
    end
  endtask

  always @(posedge clock) model_step();

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      for (int c = 0; c < 2; c++) begin
        check("model_trig", trig_out[c], m_phase[c] == 1);
        check("model_pc", pc_out[c*20 +: 20], m_pc[c]);
        check("model_id", id_out[c*5 +: 5], m_id[c]);
      end
      check("model_rdata", cfg_rdata, m_rdata);
    end
  end

  task automatic step();
    @(negedge clock);
  endtask

  task automatic cfg_write(input bit [7:0] a, input bit [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic cfg_read(input bit [7:0] a);
    cfg_re = 1'b1; cfg_addr = a;
    step();
    cfg_re = 1'b0;
  endtask

  function automatic bit [7:0] rand_addr();
    int r;
    r = $urandom_range(0, 13);
    if (r < 8) return 8'(r);
    if (r == 8) return 8'h40;
    if (r == 9) return 8'h41;
    if (r == 10) return 8'h80;
    if (r == 11) return 8'h81;
    if (r == 12) return 8'h82;
    return 8'($urandom);
  endfunction

  initial begin
    reset = 1'b0; stall = 2'b00; interrupt_ack = 2'b00; irq_in = 8'h00;
    cfg_we = 1'b0; cfg_re = 1'b0; cfg_addr = 8'h00; cfg_wdata = 32'h0;
    repeat (3) step();
    chk_en = 1'b1;
    check("reset_trig", trig_out, 2'b00);
    check("reset_pc", pc_out, 40'h0);
    reset = 1'b1;

    // Single source, stalled announce, re-arm during service.
    cfg_write(8'h03, 32'h00400);
    cfg_write(8'h40, 32'h08);
    irq_in = 8'h08; stall = 2'b01; step();
    irq_in = 8'h00;
    check("lat_no_trig_yet", trig_out[0], 1'b0);
    step();
    check("tp1_trig", trig_out[0], 1'b1);
    check("tp1_pc", pc_out[19:0], 20'h00400);
    check("tp1_id", id_out[4:0], 5'd3);
    cfg_read(8'h80);
    check("tp1_pend_cleared", cfg_rdata, 32'h0);
    repeat (3) begin
      check("stall_hold", trig_out[0], 1'b1);
      step();
    end
    check("stall_hold", trig_out[0], 1'b1);
    stall = 2'b00; step();
    check("unstalled_drop", trig_out[0], 1'b0);
    irq_in = 8'h08; step();
    irq_in = 8'h00; step();
    check("svc_no_claim", trig_out[0], 1'b0);
    cfg_read(8'h80);
    check("svc_pending", cfg_rdata, 32'h08);
    interrupt_ack = 2'b01; step();
    interrupt_ack = 2'b00;
    check("ack_idle", trig_out[0], 1'b0);
    step();
    check("retrigger", trig_out[0], 1'b1);
    step();
    interrupt_ack = 2'b01; step(); interrupt_ack = 2'b00;

    // Two cores, two sources in the same cycle.
    cfg_write(8'h40, 32'h06);
    cfg_write(8'h41, 32'h06);
    irq_in = 8'h06; step();
    irq_in = 8'h00; step();
    check("dual_trig", trig_out, 2'b11);
    check("dual_id0", id_out[4:0], 5'd1);
    check("dual_id1", id_out[9:5], 5'd2);
    step();
    interrupt_ack = 2'b11; step(); interrupt_ack = 2'b00;

    // Fixed priority: 5 before 7 on one core.
    cfg_write(8'h41, 32'h00);
    cfg_write(8'h40, 32'hA0);
    irq_in = 8'hA0; step();
    irq_in = 8'h00; step();
    check("prio_first", id_out[4:0], 5'd5);
    step();
    interrupt_ack = 2'b01; step(); interrupt_ack = 2'b00;
    step();
    check("prio_second", id_out[4:0], 5'd7);
    check("prio_second_trig", trig_out[0], 1'b1);
    step();
    interrupt_ack = 2'b01; step(); interrupt_ack = 2'b00;

    // Software set and write-1-to-clear.
    cfg_write(8'h40, 32'h00);
    cfg_write(8'h04, 32'h12345);
    cfg_write(8'h81, 32'h10);
    cfg_read(8'h80);
    check("swset_read", cfg_rdata, 32'h10);
    cfg_write(8'h40, 32'h10);
    step();
    check("swset_trig", trig_out[0], 1'b1);
    check("swset_pc", pc_out[19:0], 20'h12345);
    step();
    interrupt_ack = 2'b01; step(); interrupt_ack = 2'b00;
    cfg_write(8'h40, 32'h00);
    cfg_write(8'h81, 32'h10);
    cfg_write(8'h82, 32'h10);
    cfg_read(8'h80);
    check("w1c_read", cfg_rdata, 32'h0);
    cfg_write(8'h40, 32'h10);
    step();
    check("w1c_no_trig", trig_out[0], 1'b0);

    // Reset while core 0 is servicing.
    cfg_write(8'h81, 32'h10);
    step();
    check("pre_reset_trig", trig_out[0], 1'b1);
    step();
    reset = 1'b0; step(); reset = 1'b1;
    check("rst_trig", trig_out, 2'b00);
    check("rst_pc", pc_out[19:0], 20'h0);
    check("rst_id", id_out[4:0], 5'd0);
    cfg_read(8'h04);
    check("rst_vec", cfg_rdata, 32'h0);
    cfg_read(8'h40);
    check("rst_en", cfg_rdata, 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset         = ($urandom_range(0, 299) != 0);
      irq_in        = irq_in ^ 8'($urandom & $urandom);
      stall         = 2'($urandom);
      interrupt_ack = 2'($urandom & $urandom);
      cfg_we        = ($urandom_range(0, 5) == 0);
      cfg_re        = ($urandom_range(0, 3) == 0);
      cfg_addr      = rand_addr();
      cfg_wdata     = $urandom;
      step();
    end
    cfg_we = 1'b0; cfg_re = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
